// File: rtl/chess_pkg.sv
// Shared chess definitions: piece type codes and the board scanner FSM encoding.
// Also used by the move-set stage.
package chess_pkg;

  localparam logic [2:0] EMPTY   = 3'd0;
  localparam logic [2:0] PAWN    = 3'd1;
  localparam logic [2:0] ROOK    = 3'd2;
  localparam logic [2:0] KNIGHT  = 3'd3;
  localparam logic [2:0] BISHOP  = 3'd4;
  localparam logic [2:0] QUEEN   = 3'd5;
  localparam logic [2:0] KING    = 3'd6;
  localparam logic [2:0] INVALID = 3'd7;

  localparam logic [5:0] LAST_SQ = 6'd63;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } scan_state_e;

  // Piece code is {owner, type}; empty and invalid codes never count as a piece.
  function automatic logic is_own_piece(input logic [3:0] code, input logic owner);
    logic real_piece;
    case (code[2:0])
      PAWN, ROOK, KNIGHT, BISHOP, QUEEN, KING: real_piece = 1'b1;
      EMPTY, INVALID:                          real_piece = 1'b0;
      default:                                 real_piece = 1'b0;
    endcase
    return real_piece && (code[3] == owner);
  endfunction

endpackage

// File: rtl/board_scanner.sv
// Walks the 64-square board memory and hands each piece owned by the scanning
// side to the move-set stage. Optional BOARD_SCANNER_KING_CHECK_EN adds king_missing.
module board_scanner
  import chess_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       player,
  output logic [5:0] brd_addr,
  input  logic [3:0] brd_data,
  output logic [3:0] piece,
  output logic [5:0] square,
  output logic       side,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       done,
  output logic [6:0] count
`ifdef BOARD_SCANNER_KING_CHECK_EN
  ,
  output logic       king_missing
`endif
);

  scan_state_e state_q, state_d;
  logic [5:0]  sq_q, sq_d;
  logic [3:0]  piece_q, piece_d;
  logic [5:0]  square_q, square_d;
  logic        side_q, side_d;
  logic        valid_q, valid_d;
  logic [6:0]  count_q, count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sq_q     <= '0;
      piece_q  <= '0;
      square_q <= '0;
      side_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sq_q     <= sq_d;
      piece_q  <= piece_d;
      square_q <= square_d;
      side_q   <= side_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sq_d     = sq_q;
    piece_d  = piece_q;
    square_d = square_q;
    side_d   = side_q;
    valid_d  = valid_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          side_d  = player;
          sq_d    = '0;
          count_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = EVAL;
      EVAL: begin
        if (is_own_piece(brd_data, side_q)) begin
          piece_d  = brd_data;
          square_d = sq_q;
          valid_d  = 1'b1;
          state_d  = EMIT;
        end else if (sq_q == LAST_SQ) begin
          state_d = DONE;
        end else begin
          sq_d    = sq_q + 6'd1;
          state_d = FETCH;
        end
      end
      EMIT: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          count_d = count_q + 7'd1;
          if (sq_q == LAST_SQ) begin
            state_d = DONE;
          end else begin
            sq_d    = sq_q + 6'd1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BOARD_SCANNER_KING_CHECK_EN
  logic king_seen_q, king_seen_d;
  logic king_missing_q, king_missing_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      king_seen_q    <= 1'b0;
      king_missing_q <= 1'b0;
    end else begin
      king_seen_q    <= king_seen_d;
      king_missing_q <= king_missing_d;
    end
  end

  // Only handed-off kings count; owner already matches side by construction.
  always_comb begin
    king_seen_d    = king_seen_q;
    king_missing_d = king_missing_q;
    if (state_q == IDLE && start) begin
      king_seen_d    = 1'b0;
      king_missing_d = 1'b0;
    end else if (state_q == EMIT && valid_q && ready && piece_q[2:0] == KING) begin
      king_seen_d = 1'b1;
    end else if (state_q == DONE && !king_seen_q) begin
      king_missing_d = 1'b1;
    end
  end

  assign king_missing = king_missing_q;
`endif

  assign brd_addr = sq_q;
  assign piece    = piece_q;
  assign square   = square_q;
  assign side     = side_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_board_scanner.sv
// Scoreboard bench for board_scanner: stimulus pushes the expected emissions,
// a negedge monitor pops and compares them; done timing is checked against the scan rules.
module tb_board_scanner;

  logic       clock = 1'b0;
  logic       reset, start, player, ready;
  logic [5:0] brd_addr;
  logic [3:0] brd_data;
  logic [3:0] piece;
  logic [5:0] square;
  logic       side, valid, busy, done;
  logic [6:0] count;
`ifdef BOARD_SCANNER_KING_CHECK_EN
  logic       king_missing;
`endif

  board_scanner dut (
    .clock(clock), .reset(reset), .start(start), .player(player),
    .brd_addr(brd_addr), .brd_data(brd_data),
    .piece(piece), .square(square), .side(side), .valid(valid),
    .ready(ready), .busy(busy), .done(done), .count(count)
`ifdef BOARD_SCANNER_KING_CHECK_EN
    , .king_missing(king_missing)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] pc;
    logic [5:0] sq;
  } em_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [3:0] mem [64];
  em_t  exp_q[$];
  int   exp_count;
  logic exp_km;
  logic exp_side;
  int   start_cyc;
  bit   active = 0;
  int   vcyc;
  int   ready_mode = 0;
  int   vcnt;

  // Synchronous-read board memory: data follows the address by one cycle.
  always @(posedge clock) brd_data <= mem[brd_addr];
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ready driver: 0 tied high, 1 toggle, 2 random, 3 low for 5 valid cycles, 4 low
  initial begin
    ready = 1'b0;
    vcnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      if (valid) vcnt++; else vcnt = 0;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        2:       ready = 1'($urandom_range(0, 1));
        3:       ready = (vcnt > 5);
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    em_t  e;
    bit   have_hold;
    logic [3:0] h_pc;
    logic [5:0] h_sq;
    logic h_sd;
    logic prev_done;
    have_hold = 0;
    prev_done = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        have_hold = 0;
        prev_done = 0;
      end else begin
        if (valid) begin
          vcyc++;
          if (have_hold) begin
            check("hold_piece", 32'(piece), 32'(h_pc));
            check("hold_square", 32'(square), 32'(h_sq));
            check("hold_side", 32'(side), 32'(h_sd));
          end
          if (ready) begin
            have_hold = 0;
            if (exp_q.size() == 0) begin
              check("extra_emission_sq", 32'(square), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("emit_piece", 32'(piece), 32'(e.pc));
              check("emit_square", 32'(square), 32'(e.sq));
              check("emit_side", 32'(side), 32'(exp_side));
            end
          end else if (!have_hold) begin
            have_hold = 1;
            h_pc = piece; h_sq = square; h_sd = side;
          end
        end
        if (done) begin
          check("done_single_cycle", 32'(prev_done), 32'd0);
          if (!active) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            check("done_count", 32'(count), 32'(exp_count));
            check("done_latency", 32'(cyc - start_cyc), 32'(129 + vcyc));
            check("missed_emissions", 32'(exp_q.size()), 32'd0);
            check("done_busy", 32'(busy), 32'd1);
`ifdef BOARD_SCANNER_KING_CHECK_EN
            check("king_missing", 32'(king_missing), 32'(exp_km));
`endif
            active = 0;
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
  endtask

  task automatic build_expect(input logic pl);
    logic [2:0] t;
    bit king;
    exp_q.delete();
    king = 0;
    for (int i = 0; i < 64; i++) begin
      t = mem[i][2:0];
      if (t >= 3'd1 && t <= 3'd6 && mem[i][3] == pl) begin
        exp_q.push_back({mem[i], 6'(i)});
        if (t == 3'd6) king = 1;
      end
    end
    exp_count = exp_q.size();
    exp_km    = !king;
    exp_side  = pl;
  endtask

  task automatic do_scan(input logic pl, input int mode, input bit busy_starts);
    build_expect(pl);
    vcyc = 0;
    ready_mode = mode;
    @(posedge clock); #1;
    start = 1'b1; player = pl; start_cyc = cyc; active = 1;
    for (int i = 0; i < 4000 && active; i++) begin
      @(posedge clock); #1;
      start  = busy_starts && (i == 20 || i == 57 || i == 110);
      player = ~pl;
    end
    start = 1'b0;
    if (active) begin
      check("scan_timeout", 32'd1, 32'd0);
      active = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_count_hold", 32'(count), 32'(exp_count));
  endtask

  initial begin
    logic [3:0] back [8];
    back[0] = 4'd2; back[1] = 4'd3; back[2] = 4'd4; back[3] = 4'd5;
    back[4] = 4'd6; back[5] = 4'd4; back[6] = 4'd3; back[7] = 4'd2;
    reset = 1'b1; start = 1'b0; player = 1'b0;
    clear_board();
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(brd_addr), 32'd0);
    check("rst_piece", 32'(piece), 32'd0);
    check("rst_square", 32'(square), 32'd0);
    check("rst_side", 32'(side), 32'd0);
    reset = 1'b0;

    // empty board
    do_scan(1'b0, 0, 0);

    // pawn at 12 for side 0, king at 60 for side 1
    mem[12] = 4'b0001; mem[60] = 4'b1110;
    do_scan(1'b0, 0, 0);
    do_scan(1'b1, 3, 0);

    // invalid code on the last square
    clear_board();
    mem[63] = 4'b0111;
    do_scan(1'b0, 0, 0);

    // own piece on the last square: done right after the handshake
    mem[63] = 4'b0101;
    do_scan(1'b0, 3, 0);

    // full starting position
    clear_board();
    for (int f = 0; f < 8; f++) begin
      mem[f]      = back[f];
      mem[8 + f]  = 4'b0001;
      mem[48 + f] = 4'b1001;
      mem[56 + f] = 4'b1000 | back[f];
    end
    do_scan(1'b0, 1, 0);
    do_scan(1'b1, 2, 0);

    // reset while an emission is pending
    clear_board();
    mem[12] = 4'b0001; mem[30] = 4'b0110;
    ready_mode = 4;
    @(posedge clock); #1;
    start = 1'b1; player = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !valid; i++) @(posedge clock);
    check("pre_reset_valid", 32'(valid), 32'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_piece", 32'(piece), 32'd0);
    check("mid_rst_square", 32'(square), 32'd0);
    check("mid_rst_addr", 32'(brd_addr), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    // starts while busy are ignored
    do_scan(1'b0, 2, 1);

    // randomized boards
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++)
        mem[i] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      do_scan(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
